// File: rtl/sdu_frame_fifo_pkg.sv
// sdu_frame_fifo_pkg: shared flag positions, write FSM encoding and delay macro for the SDU frame FIFO
`ifndef U_DLY
`define U_DLY
`endif

package sdu_frame_fifo_pkg;

    // flag positions counted down from DATA_WIDTH: sop is the MSB, eop the next bit
    localparam int SOP_BIT = 1;
    localparam int EOP_BIT = 2;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_FRAME = 2'd1,
        W_DROP  = 2'd2
    } w_state_t;

endpackage

// File: rtl/sdu_fifo_ram.sv
// sdu_fifo_ram: simple dual-port RAM, synchronous write, asynchronous read
module sdu_fifo_ram #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk_sys,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk_sys)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/sdu_frame_fifo.sv
// sdu_frame_fifo: per-channel buffer exposing only complete frames to the SDU scheduler
module sdu_frame_fifo
    import sdu_frame_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys,
    input  logic                  wr_dval,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  sdu_empty,
    output logic                  sdu_dval,
    output logic [DATA_WIDTH-1:0] sdu_data,
    output logic [ADDR_WIDTH:0]   frm_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic                  wr_err
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    w_state_t state, state_nxt;
    logic [PW-1:0] wr_ptr, wr_tmp, rd_ptr, wr_ptr_nxt, wr_tmp_nxt, waddr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic sop, eop, full_ptr, full_tmp, we, commit, err_nxt, drop, rd_ok, rd_eop;

    assign sop       = wr_data[DATA_WIDTH-SOP_BIT];
    assign eop       = wr_data[DATA_WIDTH-EOP_BIT];
    assign full_ptr  = (wr_ptr - rd_ptr) == DEPTH;
    assign full_tmp  = (wr_tmp - rd_ptr) == DEPTH;
    assign sdu_empty = frm_cnt == '0;
    assign rd_ok     = rd_en && !sdu_empty;
    assign rd_eop    = rd_ok && rd_word[DATA_WIDTH-EOP_BIT];

    // a sop always restarts at the committed pointer, so its room is judged from wr_ptr
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        wr_tmp_nxt = wr_tmp;
        waddr      = wr_tmp;
        we         = 1'b0;
        commit     = 1'b0;
        err_nxt    = 1'b0;
        drop       = 1'b0;
        if (wr_dval) begin
            err_nxt = sop ? state != W_IDLE : state == W_IDLE;
            if (sop || state == W_FRAME) begin
                waddr = sop ? wr_ptr : wr_tmp;
                if (sop ? full_ptr : full_tmp) begin
                    drop       = 1'b1;
                    wr_tmp_nxt = wr_ptr;
                    state_nxt  = eop ? W_IDLE : W_DROP;
                end else begin
                    we         = 1'b1;
                    commit     = eop;
                    wr_tmp_nxt = waddr + PW'(1);
                    wr_ptr_nxt = eop ? wr_tmp_nxt : wr_ptr;
                    state_nxt  = eop ? W_IDLE : W_FRAME;
                end
            end else if (eop) begin
                state_nxt = W_IDLE;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            state    <= W_IDLE;
            wr_ptr   <= '0;
            wr_tmp   <= '0;
            rd_ptr   <= '0;
            frm_cnt  <= '0;
            drop_cnt <= '0;
            wr_err   <= 1'b0;
            sdu_dval <= 1'b0;
            sdu_data <= '0;
        end else begin
            state    <= `U_DLY state_nxt;
            wr_ptr   <= `U_DLY wr_ptr_nxt;
            wr_tmp   <= `U_DLY wr_tmp_nxt;
            wr_err   <= `U_DLY err_nxt;
            sdu_dval <= `U_DLY rd_ok;
            if (rd_ok) begin
                rd_ptr   <= `U_DLY rd_ptr + PW'(1);
                sdu_data <= `U_DLY rd_word;
            end
            if (commit != rd_eop)
                frm_cnt <= `U_DLY commit ? frm_cnt + PW'(1) : frm_cnt - PW'(1);
            if (drop && !(&drop_cnt))
                drop_cnt <= `U_DLY drop_cnt + CNT_WIDTH'(1);
        end
    end

    sdu_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_sys(clk_sys),
        .we     (we),
        .waddr  (waddr[ADDR_WIDTH-1:0]),
        .wdata  (wr_data),
        .raddr  (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata  (rd_word)
    );

endmodule

// File: tb/tb_sdu_frame_fifo.sv
// tb_sdu_frame_fifo: directed self-checking bench for sdu_frame_fifo with a 16-word buffer
module tb_sdu_frame_fifo;

    logic        clk_sys = 1'b0;
    logic        rst_sys = 1'b0;
    logic        wr_dval = 1'b0;
    logic [17:0] wr_data = '0;
    logic        rd_en   = 1'b0;
    logic        sdu_empty, sdu_dval, wr_err;
    logic [17:0] sdu_data;
    logic [4:0]  frm_cnt;
    logic [15:0] drop_cnt;
    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    always #5 clk_sys = ~clk_sys;

    sdu_frame_fifo #(
        .DATA_WIDTH(18),
        .ADDR_WIDTH(4),
        .CNT_WIDTH (16)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_sys  (rst_sys),
        .wr_dval  (wr_dval),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .sdu_empty(sdu_empty),
        .sdu_dval (sdu_dval),
        .sdu_data (sdu_data),
        .frm_cnt  (frm_cnt),
        .drop_cnt (drop_cnt),
        .wr_err   (wr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr(input logic [17:0] w);
        wr_dval = 1'b1;
        wr_data = w;
        tick();
        wr_dval = 1'b0;
        err_seen += int'(wr_err);
    endtask

    task automatic rd(input logic [17:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("rd_dval", sdu_dval, 1);
        chk("rd_data", sdu_data, exp);
    endtask

    initial begin
        tick();
        tick();
        rst_sys = 1'b1;
        tick();
        // 1: reset mid-frame
        wr(18'h200A0);
        wr(18'h000A1);
        wr(18'h000A2);
        rst_sys = 1'b0;
        #2;
        rst_sys = 1'b1;
        tick();
        chk("t1_empty", sdu_empty, 1);
        chk("t1_frm", frm_cnt, 0);
        chk("t1_drop", drop_cnt, 0);
        chk("t1_dval", sdu_dval, 0);
        wr(18'h20011);
        wr(18'h10012);
        chk("t1_frm_after", frm_cnt, 1);
        rd(18'h20011);
        rd(18'h10012);
        chk("t1_empty_after", sdu_empty, 1);
        // 2: four-word frame
        wr(18'h20001);
        wr(18'h00002);
        wr(18'h00003);
        chk("t2_empty_pre", sdu_empty, 1);
        wr(18'h10004);
        chk("t2_empty_fall", sdu_empty, 0);
        rd(18'h20001);
        rd(18'h00002);
        rd(18'h00003);
        chk("t2_empty_mid", sdu_empty, 0);
        rd(18'h10004);
        chk("t2_empty_rise", sdu_empty, 1);
        tick();
        chk("t2_dval_idle", sdu_dval, 0);
        chk("t2_data_hold", sdu_data, 18'h10004);
        // 3: overflow drops the second 10-word frame at its 7th word
        for (int i = 0; i < 10; i++) wr({i == 0, i == 9, 16'(256 + i)});
        for (int i = 0; i < 10; i++) begin
            wr({i == 0, i == 9, 16'(512 + i)});
            if (i == 5) chk("t3_drop_w6", drop_cnt, 0);
            if (i == 6) chk("t3_drop_w7", drop_cnt, 1);
        end
        chk("t3_drop", drop_cnt, 1);
        chk("t3_frm", frm_cnt, 1);
        for (int i = 0; i < 10; i++) rd({i == 0, i == 9, 16'(256 + i)});
        chk("t3_empty", sdu_empty, 1);
        chk("t3_frm_end", frm_cnt, 0);
        // 4: missing eop, then a lone non-sop word
        err_seen = 0;
        wr(18'h20300);
        wr(18'h00301);
        wr(18'h20310);
        chk("t4_err_pulse", wr_err, 1);
        wr(18'h00311);
        chk("t4_err_low", wr_err, 0);
        wr(18'h10312);
        chk("t4_err_count", err_seen, 1);
        chk("t4_frm", frm_cnt, 1);
        rd(18'h20310);
        rd(18'h00311);
        rd(18'h10312);
        chk("t4_empty", sdu_empty, 1);
        wr(18'h00400);
        chk("t4_lone_err", wr_err, 1);
        tick();
        chk("t4_lone_err_low", wr_err, 0);
        chk("t4_lone_frm", frm_cnt, 0);
        chk("t4_lone_empty", sdu_empty, 1);
        // 5: commit coincides with the eop read
        wr(18'h20500);
        wr(18'h10501);
        chk("t5_frm1", frm_cnt, 1);
        rd_en = 1'b1;
        wr(18'h20600);
        chk("t5_rd0", sdu_data, 18'h20500);
        wr(18'h10601);
        rd_en = 1'b0;
        chk("t5_frm_same", frm_cnt, 1);
        chk("t5_empty", sdu_empty, 0);
        chk("t5_dval", sdu_dval, 1);
        chk("t5_rd1", sdu_data, 18'h10501);
        rd(18'h20600);
        rd(18'h10601);
        chk("t5_empty_end", sdu_empty, 1);
        // 6: reads ignored while empty, then a single-word frame
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_dval", sdu_dval, 0);
        end
        rd_en = 1'b0;
        chk("t6_data_hold", sdu_data, 18'h10601);
        err_seen = 0;
        wr(18'h3ABCD);
        chk("t6_frm", frm_cnt, 1);
        chk("t6_no_err", err_seen, 0);
        rd(18'h3ABCD);
        chk("t6_empty", sdu_empty, 1);
        chk("t6_drop_keep", drop_cnt, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdu_frame_fifo.md
Name: sdu_frame_fifo

Overview:
Per-channel frame buffer that sits directly upstream of the 2-to-1 SDU scheduler. Each scheduler channel gets one instance.
It accepts a framed word stream: 18-bit words, [17] sop, [16] eop, [15:0] payload. It stores only complete frames and presents frame-level empty, read-enable and read-data signals to the scheduler.
Incomplete, malformed or overflowing frames never become visible to the reader.

Parameters:
DATA_WIDTH, 18, word width; [DATA_WIDTH-1] sop, [DATA_WIDTH-2] eop, rest payload
ADDR_WIDTH, 9, buffer depth = 2^ADDR_WIDTH words
CNT_WIDTH, 16, width of the saturating drop counter

Ports:
clk_sys  in  1  system clock, single clock domain
rst_sys  in  1  asynchronous reset, active-low
wr_dval  in  1  write word valid
wr_data  in  DATA_WIDTH  write word, with sop/eop flags
rd_en  in  1  read request from the scheduler (its per-channel rden)
sdu_empty  out  1  high when no complete frame is stored
sdu_dval  out  1  read data valid, one cycle after an accepted rd_en
sdu_data  out  DATA_WIDTH  read word
frm_cnt  out  ADDR_WIDTH+1  number of complete frames stored
drop_cnt  out  CNT_WIDTH  frames dropped on overflow, saturating
wr_err  out  1  one-cycle pulse on a framing error

Behaviour:
Reset (async, rst_sys=0):
- All pointers and counters cleared; write FSM to W_IDLE.
- sdu_empty=1, sdu_dval=0, sdu_data=0, frm_cnt=0, drop_cnt=0, wr_err=0.
- Any frame partially written at reset is lost.

Pointers:
- wr_ptr (committed), wr_tmp (working) and rd_ptr are ADDR_WIDTH+1 bits, with a wrap bit.
- used = wr_tmp - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- full when used == 2^ADDR_WIDTH.

Write FSM (W_IDLE, W_FRAME, W_DROP), evaluated only when wr_dval=1:
- W_IDLE, sop=1: store the word at wr_ptr; wr_tmp=wr_ptr+1; go to W_FRAME.
- W_IDLE, sop=0: discard the word, pulse wr_err, stay.
- W_FRAME, non-sop word, not full: store at wr_tmp; wr_tmp+1.
- W_FRAME, sop=1 (missing eop): abort the current frame (wr_tmp=wr_ptr), pulse wr_err, restart the frame with this word.
- Full on any word (W_IDLE or W_FRAME): discard, wr_tmp=wr_ptr, drop_cnt+1 (saturate at all-ones), go to W_DROP.
- eop=1 on a stored word: wr_ptr=wr_tmp+1 (commit), frm_cnt+1, go to W_IDLE.
- sop=1 and eop=1 together: single-word frame, committed in the same cycle.
- W_DROP: discard every word until eop, then go to W_IDLE. A sop seen in W_DROP pulses wr_err and is handled as in W_IDLE.

Read:
- Memory has an asynchronous read port; sdu_data/sdu_dval are registered.
- rd_en=1 and sdu_empty=0: sdu_data=mem[rd_ptr] next cycle, sdu_dval=1, rd_ptr+1.
- If that word has eop=1, frm_cnt decrements in the same cycle rd_en is accepted.
- rd_en while sdu_empty=1: ignored; no dval, no pointer change.
- sdu_dval=0 in every cycle without an accepted read; sdu_data holds its last value.

Empty and frame count:
- sdu_empty = (frm_cnt==0), decoded combinationally from the register.
- Empty rises the cycle after the last eop read is accepted.
- Empty falls the cycle after a commit.
- Commit and eop read in the same cycle: frm_cnt unchanged.

Other rules:
- wr_err is registered, a one-cycle pulse.
- Reader and writer never touch the same word, because reads are confined to committed space.

Decomposition:
- Shared package: SOP_BIT/EOP_BIT index constants, the write FSM state encoding and the U_DLY macro (existing DEFINES).
- One sub-module: sdu_fifo_ram, a simple dual-port RAM with async read, 2^ADDR_WIDTH x DATA_WIDTH.

Test Plan:
1. Reset mid-frame (3 words written, rst_sys pulsed) -> sdu_empty=1, frm_cnt=0, drop_cnt=0, sdu_dval=0; a following frame is read back intact.
2. Write a 4-word frame 0x2_0001, 0x0_0002, 0x0_0003, 0x1_0004; then rd_en for 4 cycles.
   - sdu_empty falls the cycle after the eop write.
   - sdu_dval is high for 4 cycles, each word 1 cycle after its rd_en, data matching in order.
   - sdu_empty rises the cycle after the 4th rd_en.
3. ADDR_WIDTH=4: write a 10-word frame, then a 10-word frame with no reads.
   - Second frame drops at word 7; drop_cnt=1, frm_cnt=1.
   - Readout yields only the first 10 words; empty afterward.
4. Framing errors:
   - sop, 2 words, then a new sop frame of 3 words ending in eop -> wr_err pulses once, frm_cnt=1, readout is the 3-word frame only.
   - Lone non-sop word in W_IDLE -> wr_err pulse, nothing stored.
5. One frame stored; commit a second frame in the same cycle the first frame's eop read is accepted -> frm_cnt stays 1, sdu_empty stays 0, second frame then reads out.
6. rd_en held with sdu_empty=1 -> no sdu_dval, rd_ptr unchanged. Single-word frame 0x3_ABCD -> frm_cnt=1; one read returns 0x3_ABCD and empty reasserts.
